// File: rtl/t_switch_vcq.sv
// Three-port (left, right, up) tree switch with per-input, per-VC FIFOs.
// Each output runs its own round-robin arbiter over the 2*VC_W queues that can reach it.
module t_switch_vcq #(
  parameter int               N      = 8,
  parameter int               A_W    = $clog2(N) + 1,
  parameter int               D_W    = 32,
  parameter int               posl   = 1,
  parameter logic [A_W-1:0]   posx   = {A_W{1'b0}},
  parameter int               VC_W   = 2,
  parameter int               FIFO_D = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VC_W-1:0][A_W+D_W:0]      l_i,
  input  logic [VC_W-1:0]                 l_i_v,
  output logic [VC_W-1:0]                 l_i_bp,
  input  logic [VC_W-1:0][A_W+D_W:0]      r_i,
  input  logic [VC_W-1:0]                 r_i_v,
  output logic [VC_W-1:0]                 r_i_bp,
  input  logic [VC_W-1:0][A_W+D_W:0]      u0_i,
  input  logic [VC_W-1:0]                 u0_i_v,
  output logic [VC_W-1:0]                 u0_i_bp,
  output logic [A_W+D_W:0]                l_o,
  output logic [VC_W-1:0]                 l_o_v,
  input  logic [VC_W-1:0]                 l_o_bp,
  output logic [A_W+D_W:0]                r_o,
  output logic [VC_W-1:0]                 r_o_v,
  input  logic [VC_W-1:0]                 r_o_bp,
  output logic [A_W+D_W:0]                u0_o,
  output logic [VC_W-1:0]                 u0_o_v,
  input  logic [VC_W-1:0]                 u0_o_bp
);
  localparam int PW = A_W + D_W + 1;
  localparam int NQ = 3 * VC_W;
  localparam int NR = 2 * VC_W;
  localparam int IW = $clog2(FIFO_D);
  localparam int CW = IW + 1;
  localparam int RW = $clog2(NR);
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;

  // Queue index q = dir*VC_W + v; output o's feeders in L,R,U0 order minus itself.
  function automatic logic [1:0] feed_dir(input int o, input int d);
    if (o == 0)      feed_dir = (d == 0) ? DIR_R : DIR_U;
    else if (o == 1) feed_dir = (d == 0) ? DIR_L : DIR_U;
    else             feed_dir = (d == 0) ? DIR_L : DIR_R;
  endfunction

  function automatic int qidx(input int o, input int r);
    return int'(feed_dir(o, r / VC_W)) * VC_W + r % VC_W;
  endfunction

  function automatic logic [1:0] route(input logic [PW-1:0] pkt, input logic [1:0] src);
    logic [A_W-1:0] addr;
    logic           up;
    addr = pkt[A_W+D_W-1:D_W];
    up   = (((addr ^ posx) >> (posl + 1)) != {A_W{1'b0}});
    case (src)
      DIR_L:   route = up ? DIR_U : DIR_R;
      DIR_R:   route = up ? DIR_U : DIR_L;
      default: route = addr[posl] ? DIR_R : DIR_L;
    endcase
  endfunction

  logic [PW-1:0] mem_q [NQ][FIFO_D];
  logic [IW-1:0] wr_q  [NQ];
  logic [IW-1:0] rd_q  [NQ];
  logic [CW-1:0] cnt_q [NQ];
  logic [CW-1:0] cnt_d [NQ];
  logic [NQ-1:0] bp_q;
  logic [PW-1:0] in_s   [NQ];
  logic [PW-1:0] head_s [NQ];
  logic [1:0]    dest_s [NQ];
  logic [NQ-1:0] in_v_s, push_s, pop_s;

  always_comb begin
    in_v_s = '0;
    for (int v = 0; v < VC_W; v++) begin
      in_s[v]            = l_i[v];
      in_s[VC_W + v]     = r_i[v];
      in_s[2 * VC_W + v] = u0_i[v];
      in_v_s[v]            = l_i_v[v];
      in_v_s[VC_W + v]     = r_i_v[v];
      in_v_s[2 * VC_W + v] = u0_i_v[v];
    end
  end

  always_comb begin
    push_s = '0;
    for (int q = 0; q < NQ; q++) begin
      head_s[q] = mem_q[q][rd_q[q]];
      dest_s[q] = route(head_s[q], 2'(q / VC_W));
      push_s[q] = in_v_s[q] && !bp_q[q];
      cnt_d[q]  = cnt_q[q] + CW'(push_s[q]) - CW'(pop_s[q]);
    end
  end

  // Storage carries no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (!rst && push_s[q]) mem_q[q][wr_q[q]] <= in_s[q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q <= '0;
      for (int q = 0; q < NQ; q++) begin
        wr_q[q]  <= '0;
        rd_q[q]  <= '0;
        cnt_q[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        wr_q[q]  <= push_s[q] ? wr_q[q] + IW'(1) : wr_q[q];
        rd_q[q]  <= pop_s[q]  ? rd_q[q] + IW'(1) : rd_q[q];
        cnt_q[q] <= cnt_d[q];
        bp_q[q]  <= (cnt_d[q] == CW'(FIFO_D));
      end
    end
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    logic [NR-1:0]   req_s;
    logic [RW-1:0]   gptr_q, gptr_d;
    logic [PW-1:0]   gout_s;
    logic [VC_W-1:0] gout_v_s, gobp_s;
    logic [NQ-1:0]   gpop_s;
    int              best_s, gnt_s;

    assign gobp_s = (o == 0) ? l_o_bp : ((o == 1) ? r_o_bp : u0_o_bp);

    // Winner is the eligible requester with the smallest cyclic distance from the pointer.
    always_comb begin
      req_s    = '0;
      best_s   = NR;
      gnt_s    = 0;
      gout_s   = '0;
      gout_v_s = '0;
      gpop_s   = '0;
      gptr_d   = gptr_q;
      for (int r = 0; r < NR; r++) begin
        req_s[r] = (cnt_q[qidx(o, r)] != '0) && (dest_s[qidx(o, r)] == 2'(o)) && !gobp_s[r % VC_W];
        if (req_s[r] && ((r + NR - int'(gptr_q)) % NR) < best_s) begin
          best_s = (r + NR - int'(gptr_q)) % NR;
          gnt_s  = r;
        end else begin
          best_s = best_s;
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (best_s < NR && gnt_s == r) begin
          gout_s               = head_s[qidx(o, r)];
          gout_v_s[r % VC_W]   = 1'b1;
          gpop_s[qidx(o, r)]   = 1'b1;
          gptr_d               = RW'((r + 1) % NR);
        end else begin
          gout_s = gout_s;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) gptr_q <= '0;
      else     gptr_q <= gptr_d;
    end
  end

  assign pop_s   = g_out[0].gpop_s | g_out[1].gpop_s | g_out[2].gpop_s;
  assign l_o     = g_out[0].gout_s;
  assign l_o_v   = g_out[0].gout_v_s;
  assign r_o     = g_out[1].gout_s;
  assign r_o_v   = g_out[1].gout_v_s;
  assign u0_o    = g_out[2].gout_s;
  assign u0_o_v  = g_out[2].gout_v_s;
  assign l_i_bp  = bp_q[VC_W-1:0];
  assign r_i_bp  = bp_q[2*VC_W-1:VC_W];
  assign u0_i_bp = bp_q[NQ-1:2*VC_W];

endmodule

// File: tb/tb_t_switch_vcq.sv
// Directed bench for t_switch_vcq at A_W=4, D_W=32, posl=1, posx=4'b1010, VC_W=2, FIFO_D=4.
module tb_t_switch_vcq;
  localparam int VC_W = 2;
  localparam int PW   = 37;

  logic clk = 1'b0;
  logic rst;
  logic [VC_W-1:0][PW-1:0] l_i, r_i, u0_i;
  logic [VC_W-1:0] l_i_v, r_i_v, u0_i_v, l_i_bp, r_i_bp, u0_i_bp;
  logic [PW-1:0]   l_o, r_o, u0_o;
  logic [VC_W-1:0] l_o_v, r_o_v, u0_o_v, l_o_bp, r_o_bp, u0_o_bp;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  t_switch_vcq #(.N(8), .A_W(4), .D_W(32), .posl(1), .posx(4'b1010), .VC_W(2), .FIFO_D(4)) dut (
    .clk(clk), .rst(rst),
    .l_i(l_i), .l_i_v(l_i_v), .l_i_bp(l_i_bp),
    .r_i(r_i), .r_i_v(r_i_v), .r_i_bp(r_i_bp),
    .u0_i(u0_i), .u0_i_v(u0_i_v), .u0_i_bp(u0_i_bp),
    .l_o(l_o), .l_o_v(l_o_v), .l_o_bp(l_o_bp),
    .r_o(r_o), .r_o_v(r_o_v), .r_o_bp(r_o_bp),
    .u0_o(u0_o), .u0_o_v(u0_o_v), .u0_o_bp(u0_o_bp)
  );

  function automatic logic [PW-1:0] pk(input logic f, input logic [3:0] a, input logic [31:0] d);
    return {f, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    l_i = '0; r_i = '0; u0_i = '0;
    l_i_v = 2'b00; r_i_v = 2'b00; u0_i_v = 2'b00;
    l_o_bp = 2'b00; r_o_bp = 2'b00; u0_o_bp = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    // reset state
    chk("rst_l_o_v", l_o_v, 2'b00);
    chk("rst_r_o_v", r_o_v, 2'b00);
    chk("rst_u0_o_v", u0_o_v, 2'b00);
    chk("rst_r_o", r_o, 37'h0);
    chk("rst_bp", {l_i_bp, r_i_bp, u0_i_bp}, 6'b000000);
    rst = 1'b0;

    // single packet L VC0 -> R, one cycle latency
    l_i[0] = pk(1'b0, 4'b1010, 32'hABCDABCD);
    l_i_v  = 2'b01;
    tick();
    l_i_v  = 2'b00;
    chk("t1_r_o_v", r_o_v, 2'b01);
    chk("t1_r_o", r_o, pk(1'b0, 4'b1010, 32'hABCDABCD));
    chk("t1_l_o_v", l_o_v, 2'b00);
    chk("t1_u0_o_v", u0_o_v, 2'b00);
    chk("t1_l_o", l_o, 37'h0);
    tick();
    chk("t1_idle_v", {l_o_v, r_o_v, u0_o_v}, 6'b000000);

    // fill under backpressure, 5th rejected, then drain back to back
    r_o_bp = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      l_i[0] = pk(1'b0, 4'b1010, 32'(k));
      l_i_v  = 2'b01;
      tick();
      if (k == 4) chk("t2_bp_after4", l_i_bp, 2'b01);
      chk("t2_r_blocked", r_o_v, 2'b00);
    end
    chk("t2_bp_after5", l_i_bp, 2'b01);
    l_i_v  = 2'b00;
    r_o_bp = 2'b00;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_v", r_o_v, 2'b01);
      chk("t2_drain_d", r_o, pk(1'b0, 4'b1010, 32'(k)));
      tick();
    end
    chk("t2_fifth_lost", r_o_v, 2'b00);
    chk("t2_bp_clear", l_i_bp, 2'b00);

    // L VC1 and U0 VC1 contend for R VC1
    do_reset();
    l_i[1]  = pk(1'b0, 4'b1010, 32'h11111111);
    u0_i[1] = pk(1'b1, 4'b0010, 32'hEEEEEEEE);
    l_i_v   = 2'b10;
    u0_i_v  = 2'b10;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_r_o_v", r_o_v, 2'b10);
      chk("t3_r_o", r_o, (k % 2 == 0) ? pk(1'b0, 4'b1010, 32'h11111111) : pk(1'b1, 4'b0010, 32'hEEEEEEEE));
      chk("t3_l_o_v", l_o_v, 2'b00);
      tick();
    end

    // round-robin across VCs on U0, then VC0 blocked
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        l_i[0] = pk(1'b0, 4'b0000, 32'h100 + 32'(k));
        l_i[1] = pk(1'b0, 4'b0000, 32'h200 + 32'(k));
        l_i_v  = 2'b11;
      end else begin
        l_i_v  = 2'b00;
      end
      tick();
      chk("t4_u0_o_v", u0_o_v, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t4_u0_o", u0_o, pk(1'b0, 4'b0000, ((k % 2 == 0) ? 32'h100 : 32'h200) + 32'(k / 2)));
    end
    l_i_v = 2'b00;
    tick();
    chk("t4_empty", u0_o_v, 2'b00);
    l_i[0]  = pk(1'b0, 4'b0000, 32'h103);
    l_i[1]  = pk(1'b0, 4'b0000, 32'h203);
    l_i_v   = 2'b11;
    u0_o_bp = 2'b01;
    tick();
    l_i_v   = 2'b00;
    chk("t4_bp_vc1_v", u0_o_v, 2'b10);
    chk("t4_bp_vc1_d", u0_o, pk(1'b0, 4'b0000, 32'h203));
    tick();
    chk("t4_bp_vc0_held", u0_o_v, 2'b00);
    u0_o_bp = 2'b00;
    #1;
    chk("t4_release_v", u0_o_v, 2'b01);
    chk("t4_release_d", u0_o, pk(1'b0, 4'b0000, 32'h103));

    // all six queues loaded, three concurrent grants
    do_reset();
    l_i[0]  = pk(1'b0, 4'b0000, 32'hA0);
    l_i[1]  = pk(1'b0, 4'b0000, 32'hA1);
    r_i[0]  = pk(1'b0, 4'b1000, 32'hB0);
    r_i[1]  = pk(1'b0, 4'b0000, 32'hB1);
    u0_i[0] = pk(1'b0, 4'b0010, 32'hC0);
    u0_i[1] = pk(1'b0, 4'b0000, 32'hC1);
    l_i_v = 2'b11; r_i_v = 2'b11; u0_i_v = 2'b11;
    tick();
    l_i_v = 2'b00; r_i_v = 2'b00; u0_i_v = 2'b00;
    chk("t5_c1_valid", {l_o_v, r_o_v, u0_o_v}, 6'b010101);
    chk("t5_c1_u0", u0_o, pk(1'b0, 4'b0000, 32'hA0));
    chk("t5_c1_l", l_o, pk(1'b0, 4'b1000, 32'hB0));
    chk("t5_c1_r", r_o, pk(1'b0, 4'b0010, 32'hC0));
    tick();
    chk("t5_c2_valid", {l_o_v, r_o_v, u0_o_v}, 6'b100010);
    chk("t5_c2_u0", u0_o, pk(1'b0, 4'b0000, 32'hA1));
    chk("t5_c2_l", l_o, pk(1'b0, 4'b0000, 32'hC1));
    chk("t5_c2_r", r_o, 37'h0);
    tick();
    chk("t5_c3_valid", {l_o_v, r_o_v, u0_o_v}, 6'b000010);
    chk("t5_c3_u0", u0_o, pk(1'b0, 4'b0000, 32'hB1));
    tick();
    chk("t5_c4_valid", {l_o_v, r_o_v, u0_o_v}, 6'b000000);

    // reset discards queued packets
    do_reset();
    u0_o_bp = 2'b11;
    for (int k = 0; k < 3; k++) begin
      l_i[0] = pk(1'b0, 4'b0000, 32'h300 + 32'(k));
      l_i_v  = 2'b01;
      tick();
    end
    l_i_v = 2'b00;
    chk("t6_held", u0_o_v, 2'b00);
    chk("t6_not_full", l_i_bp, 2'b00);
    rst = 1'b1;
    tick();
    u0_o_bp = 2'b00;
    #1;
    chk("t6_rst_valid", {l_o_v, r_o_v, u0_o_v}, 6'b000000);
    chk("t6_rst_bp", {l_i_bp, r_i_bp, u0_i_bp}, 6'b000000);
    chk("t6_rst_u0_o", u0_o, 37'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_never_out", u0_o_v, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t_switch_vcq.md
T_SWITCH_VCQ -- requirements
Module: t_switch_vcq

Interface
REQ-001 SHALL have parameter N, default DEFAULT_N, number of clients.
REQ-002 SHALL have parameter A_W, default DEFAULT_A_W, address width ($clog2(N)+1).
REQ-003 SHALL have parameter D_W, default DEFAULT_D_W, data width.
REQ-004 SHALL have parameter posl, default 1, tree level.
REQ-005 SHALL have parameter posx, default 0, switch position; A_W bits wide.
REQ-006 SHALL have parameter VC_W, default DEFAULT_VC_W, virtual channel count (>=1).
REQ-007 SHALL have parameter FIFO_D, default 4, per-input-per-VC queue depth; power of 2, >=2.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-009 SHALL have ports, for each direction X in {l, r, u0}: X_i in [VC_W][A_W+D_W+1] per-VC payload; X_i_v in VC_W valid; X_i_bp out VC_W backpressure.
REQ-010 SHALL have ports, for each X in {l, r, u0}: X_o out A_W+D_W+1 payload; X_o_v out VC_W one-hot-or-zero valid; X_o_bp in VC_W downstream backpressure.
REQ-011 SHALL use payload layout: bit A_W+D_W = flag, [A_W+D_W-1:D_W] = addr, [D_W-1:0] = data; all bits forwarded unmodified.

Function
REQ-012 SHALL hold one FIFO of FIFO_D entries per input direction per VC (3*VC_W queues).
REQ-013 SHALL push X_i[v] when X_i_v[v] && !X_i_bp[v]; X_i_bp[v] SHALL equal queue-full, registered; a full queue rejects a push even when it pops that cycle.
REQ-014 SHALL route each queue head as follows: up = addr[A_W-1:posl+1] != posx[A_W-1:posl+1]; otherwise right if addr[posl]=1, else left.
REQ-015 SHALL send L heads with up to U0, else to R; R heads with up to U0, else to L; U0 heads to L/R by addr[posl] (no U-turn).
REQ-016 SHALL preserve the VC: a head in input VC v competes only for output VC v.
REQ-017 SHALL give each output 2*VC_W requesters, index = d*VC_W+v, where d=0/1 is the first/second feeding direction in the order L,R,U0.
REQ-018 SHALL make a requester eligible when its queue is non-empty, its head routes to this output, and X_o_bp[v]=0.
REQ-019 SHALL arbitrate each output round-robin: grant the first eligible index at or after ptr, cyclically; on grant ptr <= grant+1 mod 2*VC_W; with no grant ptr holds.
REQ-020 SHALL compute grants combinationally from registered queue state and current X_o_bp. Granted output: X_o_v[v]=1, X_o = head. The transfer completes that cycle and the head pops at the next edge.
REQ-021 SHALL drive X_o_v=0 and X_o=0 when no grant.
REQ-022 SHALL give a packet pushed at edge t a minimum latency of one cycle: it is visible on the output in cycle t+1.
REQ-023 SHALL keep outputs independent: concurrent grants on all three outputs are allowed; each queue head is granted by at most one output.
REQ-024 SHALL pop at most one entry per queue per cycle and push at most one; simultaneous push and pop on a non-full queue keeps the occupancy unchanged.
REQ-025 SHALL use pointer/count arithmetic with $clog2(FIFO_D) index bits that wrap modulo FIFO_D; the occupancy counter SHALL be $clog2(FIFO_D)+1 bits.

Reset
REQ-026 SHALL, with rst=1 at an edge: empty all queues; set all arbiter ptr to 0; X_i_bp=0; X_o_v=0; X_o=0; discard in-flight contents.
REQ-027 SHALL ignore inputs during reset and accept a push on the first edge with rst=0.

Verification
REQ-028 SHALL verify at A_W=4, D_W=32, posl=1, posx=4'b1010, VC_W=2, FIFO_D=4: single push l_i[0]={0,1010,ABCDABCD} -> next cycle r_o_v=01, r_o equal, the others 0; the following cycle all valid 0.
REQ-029 SHALL verify: r_o_bp=01 held while pushing 5 packets on l VC0 -> l_i_bp[0]=1 after the 4th push, 5th rejected; release -> 4 packets out in order, back to back.
REQ-030 SHALL verify: l VC1 {0,1010,11111111} and u0 VC1 {1,0010,EEEEEEEE}, each refilled continuously -> r_o alternates L,U0,L,U0 with r_o_v=10.
REQ-031 SHALL verify: l VC0 and l VC1 both ascending -> u0_o_v alternates 01,10 (round-robin across VCs); u0_o_bp=01 -> only VC1 is served.
REQ-032 SHALL verify: all 6 queues loaded, routed as L0/L1/R1 up, R0 left, U0[0] right, U0[1] left -> all three outputs are valid in the same cycle, with no queue granted twice.
REQ-033 SHALL verify: rst asserted with 3 packets queued -> the next cycle all outputs and bp are 0; queued packets never emerge.
